buttons_reader: RTL and testbench
=================================

# buttons_reader

Input-side companion to the board LED driver: samples four asynchronous push-buttons/switches, synchronizes them to `CLK`, debounces each channel on a shared prescaled tick, and presents clean levels plus single-cycle press/release pulses. It sits between the board pinout and the user logic, using the same carry-out prescaler scheme as the output driver.

## Interface
- `COUNTER_WIDTH`, default 24: prescaler width. One debounce tick every 2^COUNTER_WIDTH cycles.
- `DEBOUNCE_TICKS`, default 3: consecutive disagreeing ticks needed to accept a new level. Legal range 1..15.
- `CLK` input, 1 bit: single clock.
- `RSTN` input, 1 bit: reset, synchronous, active-low.
- `BTN` input, 4 bits: raw asynchronous button levels, active-high.
- `DATA` output, 4 bits: debounced levels.
- `PRESSED` output, 4 bits: one-cycle pulse per channel on a 0->1 accept.
- `RELEASED` output, 4 bits: one-cycle pulse per channel on a 1->0 accept. Present only with the macro (see Configuration).

## Operation
- **Synchronizer:** two flops per bit, `BTN` -> `s1` -> `s2`. Reset value 0. Only `s2` is used downstream.
- **Prescaler:** register `{tick, counter} <= counter + 1`; both reset to 0. `tick` is high for exactly one cycle when `counter` wraps from all-ones to 0.
- **Per-channel state:** stable level `lvl` (drives `DATA[i]`, reset 0) and 4-bit count `cnt` (reset 0).
- **On a `tick` cycle, per channel:**
  - `s2 == lvl`: `cnt <= 0`.
  - `s2 != lvl` and `cnt == DEBOUNCE_TICKS-1`: `lvl <= s2`, `cnt <= 0`. Pulse `PRESSED[i]` if `s2=1`, `RELEASED[i]` if `s2=0`.
  - `s2 != lvl` otherwise: `cnt <= cnt + 1`.
- **Off-tick cycles:** `lvl` and `cnt` hold. Pulses are 0.
- **Glitch:** any tick where `s2 == lvl` clears the count, so the disagreement must be seen on consecutive ticks.
- **Independence:** channels are independent. Several channels may accept on the same tick, and their pulses coincide.
- **Reset:** `RSTN=0` in any cycle, including mid-count, clears every register on the next edge. All outputs read 0 after that edge.
- **Counter overflow:** `cnt` cannot exceed `DEBOUNCE_TICKS-1`. A value of 15 never occurs with legal parameters.

## Timing
- Reset values: `DATA=0`, `PRESSED=0`, `RELEASED=0`.
- Synchronizer latency is 2 cycles, from `BTN` change to `s2`.
- First `tick` occurs 2^COUNTER_WIDTH cycles after the first edge with `RSTN=1`. Later ticks follow every 2^COUNTER_WIDTH cycles.
- Accept latency, from `s2` stable to the `DATA` change: DEBOUNCE_TICKS ticks, counting the first tick on which `s2` differs.
- `DATA[i]` changes on the same edge that raises its pulse. The pulse drops on the next edge.
- All outputs are registered. There is no combinational path from `BTN`.

## Configuration
- Macro: `BUTTONS_READER_RELEASE_EN`.
- **Defined:** `RELEASED` is generated as described above.
- **Undefined:** release-pulse logic is not built and `RELEASED` is tied to 4'b0000. `DATA` and `PRESSED` are unaffected.

## Structure
- **Shared package `board_io_pkg`:**
  - channel count constant `BOARD_IO_CHANNELS = 4`;
  - debounce count width constant (4);
  - the reset level constant (0), shared with the LED driver's pin constants.
- **Sub-module `debounce_channel`:**
  - inputs: `CLK`, `RSTN`, `tick`, `s2` bit;
  - outputs: `lvl`, rise pulse, fall pulse;
  - instantiated once per channel by a generate loop.
- The top level holds the synchronizer and the prescaler only.

## Test plan
All scenarios use `COUNTER_WIDTH=4` (tick every 16 cycles) and `DEBOUNCE_TICKS=3`.

1. **Reset:** hold `RSTN=0` for 5 cycles with `BTN=4'b1111`, then release. Required: `DATA=0` and pulses 0 throughout reset. `tick` first rises 16 cycles after release.
2. **Clean press:** set `BTN[0]=1` well before the first tick and hold. Required: `DATA[0]` rises on the 3rd tick, with `PRESSED=4'b0001` for exactly one cycle on that edge. `RELEASED` stays 0.
3. **Bounce:** set `BTN[1]=1` across 2 ticks, drop it to 0 covering the 3rd tick, then hold it at 1. Required: no accept at tick 3. `DATA[1]` rises 3 ticks after the re-assertion.
4. **Release:** from `DATA=4'b0001`, drop `BTN[0]` and hold. Required: `DATA[0]` falls on the 3rd tick. `RELEASED=4'b0001` for one cycle with the macro; 4'b0000 without it.
5. **Simultaneous:** raise `BTN=4'b1010` in the same cycle. Required: `DATA=4'b1010` and `PRESSED=4'b1010` on the same edge.
6. **Reset mid-count:** assert `RSTN=0` for 1 cycle after 2 disagreeing ticks, keeping `BTN[2]=1`. Required: the count restarts. `DATA[2]` rises only on the 3rd tick after reset release.

Source files
------------

// File: rtl/board_io_pkg.sv
// Shared board I/O definitions used by the button reader and the LED driver.
// Holds the channel count, the debounce counter width and the pin reset level.
package board_io_pkg;

    localparam int BOARD_IO_CHANNELS = 4;
    localparam int DEBOUNCE_CNT_W    = 4;

    // Level every board pin register takes in reset, inputs and outputs alike.
    localparam logic BOARD_IO_RESET_LEVEL = 1'b0;

    typedef logic [DEBOUNCE_CNT_W-1:0]    debounce_cnt_t;
    typedef logic [BOARD_IO_CHANNELS-1:0] board_io_vec_t;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: accepts a new level after DEBOUNCE_TICKS consecutive
// prescaler ticks on which the synchronized input disagrees with the held
// level, and raises a one-cycle rise/fall pulse on the accepting edge.
// BUTTONS_READER_RELEASE_EN: when defined the fall pulse is built, otherwise
// fall_o is a constant 0.
module debounce_channel
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 3
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic tick_i,
    input  logic s2_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    // Count value on which the next disagreeing tick accepts the new level.
    localparam debounce_cnt_t CNT_LAST = debounce_cnt_t'(DEBOUNCE_TICKS - 1);

    logic          lvl_q, lvl_d;
    debounce_cnt_t cnt_q, cnt_d;
    logic          rise_q, rise_d;
`ifdef BUTTONS_READER_RELEASE_EN
    logic          fall_q, fall_d;
`endif

    // Next-state: only tick cycles move the count; a single agreeing tick clears it.
    always_comb begin
        lvl_d  = lvl_q;
        cnt_d  = cnt_q;
        rise_d = 1'b0;
`ifdef BUTTONS_READER_RELEASE_EN
        fall_d = 1'b0;
`endif
        if (tick_i) begin
            if (s2_i == lvl_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                lvl_d  = s2_i;
                cnt_d  = '0;
                rise_d = s2_i;
`ifdef BUTTONS_READER_RELEASE_EN
                fall_d = ~s2_i;
`endif
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State and pulse registers; pulses therefore last exactly one cycle.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            lvl_q  <= BOARD_IO_RESET_LEVEL;
            cnt_q  <= '0;
            rise_q <= 1'b0;
`ifdef BUTTONS_READER_RELEASE_EN
            fall_q <= 1'b0;
`endif
        end else begin
            lvl_q  <= lvl_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
`ifdef BUTTONS_READER_RELEASE_EN
            fall_q <= fall_d;
`endif
        end
    end

    assign lvl_o  = lvl_q;
    assign rise_o = rise_q;
`ifdef BUTTONS_READER_RELEASE_EN
    assign fall_o = fall_q;
`else
    assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/buttons_reader.sv
// Board button reader: two-flop synchronizer and carry-out prescaler feeding
// one debounce_channel per button. Every output comes straight from a flop.
// BUTTONS_READER_RELEASE_EN: when defined RELEASED carries fall pulses,
// otherwise the channels tie their fall outputs low and RELEASED reads 0.
module buttons_reader
    import board_io_pkg::*;
#(
    parameter int COUNTER_WIDTH  = 24,
    parameter int DEBOUNCE_TICKS = 3
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic [BOARD_IO_CHANNELS-1:0] BTN,
    output logic [BOARD_IO_CHANNELS-1:0] DATA,
    output logic [BOARD_IO_CHANNELS-1:0] PRESSED,
    output logic [BOARD_IO_CHANNELS-1:0] RELEASED
);

    logic [BOARD_IO_CHANNELS-1:0] s1_q, s2_q;
    logic [COUNTER_WIDTH-1:0]     counter_q, counter_d;
    logic                         tick_q, tick_d;
    logic [BOARD_IO_CHANNELS-1:0] fall_w;

    // Prescaler increment; the carry out becomes the tick for one cycle on wrap.
    always_comb begin
        {tick_d, counter_d} = {1'b0, counter_q} + 1'b1;
    end

    // Synchronizer and prescaler registers.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            s1_q      <= {BOARD_IO_CHANNELS{BOARD_IO_RESET_LEVEL}};
            s2_q      <= {BOARD_IO_CHANNELS{BOARD_IO_RESET_LEVEL}};
            counter_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            s1_q      <= BTN;
            s2_q      <= s1_q;
            counter_q <= counter_d;
            tick_q    <= tick_d;
        end
    end

    for (genvar i = 0; i < BOARD_IO_CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_ch (
            .CLK   (CLK),
            .RSTN  (RSTN),
            .tick_i(tick_q),
            .s2_i  (s2_q[i]),
            .lvl_o (DATA[i]),
            .rise_o(PRESSED[i]),
            .fall_o(fall_w[i])
        );
    end

    assign RELEASED = fall_w;

endmodule

// File: tb/tb_buttons_reader.sv
// Bench for buttons_reader with a 16-cycle tick and 3-tick debounce. A
// reference model built from the debounce rules runs alongside the DUT;
// scenario tasks also check fixed accept cycles derived by hand.
module tb_buttons_reader;

    localparam int CW     = 4;
    localparam int DT     = 3;
    localparam int PERIOD = 1 << CW;

    logic       CLK  = 1'b0;
    logic       RSTN = 1'b0;
    logic [3:0] BTN  = 4'b0000;
    wire  [3:0] DATA, PRESSED, RELEASED;

    always #5 CLK = ~CLK;

    buttons_reader #(
        .COUNTER_WIDTH (CW),
        .DEBOUNCE_TICKS(DT)
    ) dut (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .BTN     (BTN),
        .DATA    (DATA),
        .PRESSED (PRESSED),
        .RELEASED(RELEASED)
    );

    int n_checks = 0;
    int n_fail   = 0;

`ifdef BUTTONS_READER_RELEASE_EN
    localparam logic [3:0] REL_BIT0 = 4'b0001;
`else
    localparam logic [3:0] REL_BIT0 = 4'b0000;
`endif

    // Reference model: BTN reaches the debouncer two edges late; a tick is seen
    // on every PERIOD-th edge after reset; a channel flips after DT consecutive
    // ticks that disagree with its level.
    logic [3:0] m_btn_d1 = '0, m_btn_d2 = '0;
    logic [3:0] m_data = '0, m_pressed = '0, m_released = '0;
    int         m_run[4];
    int         cyc = 0;

    always @(posedge CLK) begin
        logic [3:0] seen;
        if (!RSTN) begin
            m_btn_d1 = '0; m_btn_d2 = '0;
            m_data = '0; m_pressed = '0; m_released = '0;
            for (int c = 0; c < 4; c++) m_run[c] = 0;
            cyc = 0;
        end else begin
            seen = m_btn_d2;
            m_btn_d2 = m_btn_d1;
            m_btn_d1 = BTN;
            m_pressed = '0;
            m_released = '0;
            if (cyc > 0 && (cyc % PERIOD) == 0) begin
                for (int c = 0; c < 4; c++) begin
                    if (seen[c] == m_data[c]) begin
                        m_run[c] = 0;
                    end else begin
                        m_run[c] = m_run[c] + 1;
                        if (m_run[c] == DT) begin
                            m_data[c] = seen[c];
                            m_run[c] = 0;
                            if (seen[c]) m_pressed[c] = 1'b1;
`ifdef BUTTONS_READER_RELEASE_EN
                            else m_released[c] = 1'b1;
`endif
                        end
                    end
                end
            end
            cyc = cyc + 1;
        end
    end

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        int rise_at = -1;
        logic [3:0] d_at = '0, p_at = '0;
        RSTN = 1'b0;
        BTN  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if ({DATA, PRESSED, RELEASED} !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_hold k=%0d got D=%b P=%b R=%b want all 0", k, DATA, PRESSED, RELEASED);
            end
        end
        RSTN = 1'b1;
        for (int k = 0; k < 70 && rise_at < 0; k++) begin
            step();
            n_checks++;
            if ({DATA, PRESSED, RELEASED} !== {m_data, m_pressed, m_released}) begin
                n_fail++;
                $display("FAIL reset_model cyc=%0d got D=%b P=%b R=%b want D=%b P=%b R=%b",
                         cyc, DATA, PRESSED, RELEASED, m_data, m_pressed, m_released);
            end
            if (DATA !== 4'b0000) begin rise_at = cyc; d_at = DATA; p_at = PRESSED; end
        end
        n_checks++;
        if (rise_at != 3 * PERIOD + 1 || d_at !== 4'b1111 || p_at !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_first_accept got cyc=%0d D=%b P=%b want cyc=%0d D=1111 P=1111",
                     rise_at, d_at, p_at, 3 * PERIOD + 1);
        end
    endtask

    task automatic test_clean_press();
        int rise_at = -1;
        logic [3:0] p_at = '0, r_at = '0;
        RSTN = 1'b0; BTN = 4'b0000;
        step(); step();
        RSTN = 1'b1; BTN = 4'b0001;
        for (int k = 0; k < 70 && rise_at < 0; k++) begin
            step();
            n_checks++;
            if ({DATA, PRESSED, RELEASED} !== {m_data, m_pressed, m_released}) begin
                n_fail++;
                $display("FAIL press_model cyc=%0d got D=%b P=%b R=%b want D=%b P=%b R=%b",
                         cyc, DATA, PRESSED, RELEASED, m_data, m_pressed, m_released);
            end
            if (DATA[0] === 1'b1) begin rise_at = cyc; p_at = PRESSED; r_at = RELEASED; end
        end
        n_checks++;
        if (rise_at != 49 || p_at !== 4'b0001 || r_at !== 4'b0000) begin
            n_fail++;
            $display("FAIL press_accept got cyc=%0d P=%b R=%b want cyc=49 P=0001 R=0000", rise_at, p_at, r_at);
        end
        step();
        n_checks++;
        if (DATA !== 4'b0001 || PRESSED !== 4'b0000) begin
            n_fail++;
            $display("FAIL press_pulse_drop got D=%b P=%b want D=0001 P=0000", DATA, PRESSED);
        end
    endtask

    task automatic test_bounce();
        int rise_at = -1;
        BTN[1] = 1'b1;
        for (int k = 0; k < 200 && cyc < 85; k++) begin
            step();
            n_checks++;
            if ({DATA, PRESSED, RELEASED} !== {m_data, m_pressed, m_released}) begin
                n_fail++;
                $display("FAIL bounce_model cyc=%0d got D=%b P=%b want D=%b P=%b", cyc, DATA, PRESSED, m_data, m_pressed);
            end
        end
        BTN[1] = 1'b0;
        for (int k = 0; k < 200 && cyc < 100; k++) step();
        n_checks++;
        if (DATA !== 4'b0001) begin
            n_fail++;
            $display("FAIL bounce_no_accept got D=%b want 0001", DATA);
        end
        BTN[1] = 1'b1;
        for (int k = 0; k < 80 && rise_at < 0; k++) begin
            step();
            if (DATA[1] === 1'b1) rise_at = cyc;
        end
        n_checks++;
        if (rise_at != 145 || PRESSED !== 4'b0010) begin
            n_fail++;
            $display("FAIL bounce_accept got cyc=%0d P=%b want cyc=145 P=0010", rise_at, PRESSED);
        end
    endtask

    task automatic test_release();
        int fall_at = -1;
        logic [3:0] d_at = '0, p_at = '0, r_at = '0;
        BTN[0] = 1'b0;
        for (int k = 0; k < 80 && fall_at < 0; k++) begin
            step();
            n_checks++;
            if ({DATA, PRESSED, RELEASED} !== {m_data, m_pressed, m_released}) begin
                n_fail++;
                $display("FAIL release_model cyc=%0d got D=%b P=%b R=%b want D=%b P=%b R=%b",
                         cyc, DATA, PRESSED, RELEASED, m_data, m_pressed, m_released);
            end
            if (DATA[0] === 1'b0) begin fall_at = cyc; d_at = DATA; p_at = PRESSED; r_at = RELEASED; end
        end
        n_checks++;
        if (fall_at != 193 || d_at !== 4'b0010 || p_at !== 4'b0000 || r_at !== REL_BIT0) begin
            n_fail++;
            $display("FAIL release_accept got cyc=%0d D=%b P=%b R=%b want cyc=193 D=0010 P=0000 R=%b",
                     fall_at, d_at, p_at, r_at, REL_BIT0);
        end
        step();
        n_checks++;
        if (RELEASED !== 4'b0000) begin
            n_fail++;
            $display("FAIL release_pulse_drop got R=%b want 0000", RELEASED);
        end
    endtask

    task automatic test_simultaneous();
        int rise_at = -1;
        logic [3:0] d_at = '0, p_at = '0;
        RSTN = 1'b0; BTN = 4'b0000;
        step(); step();
        RSTN = 1'b1; BTN = 4'b1010;
        for (int k = 0; k < 70 && rise_at < 0; k++) begin
            step();
            if (DATA !== 4'b0000) begin rise_at = cyc; d_at = DATA; p_at = PRESSED; end
        end
        n_checks++;
        if (rise_at != 49 || d_at !== 4'b1010 || p_at !== 4'b1010) begin
            n_fail++;
            $display("FAIL simultaneous got cyc=%0d D=%b P=%b want cyc=49 D=1010 P=1010", rise_at, d_at, p_at);
        end
    endtask

    task automatic test_reset_mid_count();
        int rise_at = -1;
        RSTN = 1'b0; BTN = 4'b0000;
        step(); step();
        RSTN = 1'b1; BTN = 4'b0100;
        for (int k = 0; k < 100 && cyc < 40; k++) step();
        RSTN = 1'b0;
        step();
        n_checks++;
        if ({DATA, PRESSED, RELEASED} !== 12'h000) begin
            n_fail++;
            $display("FAIL midreset_clear got D=%b P=%b R=%b want all 0", DATA, PRESSED, RELEASED);
        end
        RSTN = 1'b1;
        for (int k = 0; k < 70 && rise_at < 0; k++) begin
            step();
            if (DATA[2] === 1'b1) rise_at = cyc;
        end
        n_checks++;
        if (rise_at != 49 || PRESSED !== 4'b0100) begin
            n_fail++;
            $display("FAIL midreset_accept got cyc=%0d P=%b want cyc=49 P=0100", rise_at, PRESSED);
        end
    endtask

    task automatic test_random();
        RSTN = 1'b0; BTN = 4'b0000;
        step(); step();
        RSTN = 1'b1;
        for (int seg = 0; seg < 40; seg++) begin
            int hold;
            BTN  = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 60);
            RSTN = ($urandom_range(0, 19) != 0);
            for (int k = 0; k < hold; k++) begin
                step();
                RSTN = 1'b1;
                n_checks++;
                if ({DATA, PRESSED, RELEASED} !== {m_data, m_pressed, m_released}) begin
                    n_fail++;
                    $display("FAIL random_model seg=%0d cyc=%0d got D=%b P=%b R=%b want D=%b P=%b R=%b",
                             seg, cyc, DATA, PRESSED, RELEASED, m_data, m_pressed, m_released);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_simultaneous();
        test_reset_mid_count();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
